event_flasher: RTL
==================

EVENT_FLASHER -- requirements
Module: event_flasher

Interface
REQ-001 SHALL have parameter CNT_W, default 10, width of the on/off interval timer.
REQ-002 SHALL have parameter ON_CYCLES, default 1023, LED-on duration per flash, in clk cycles (1 to 2^CNT_W-1).
REQ-003 SHALL have parameter OFF_CYCLES, default 1023, mandatory LED-off gap after each flash, in clk cycles (1 to 2^CNT_W-1).
REQ-004 SHALL have parameter PEND_W, default 4, width of the pending-event counter.
REQ-005 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port tick_in, input, 1, single-cycle event strobe (e.g. from a debounced push-button tick).
REQ-008 SHALL have port led, output, 1, visible flash output, registered.
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have port pending, output, PEND_W, count of queued events not yet flashed.
REQ-011 SHALL have port done_tick, output, 1, one-cycle pulse when a flash/gap sequence completes.
REQ-012 SHALL have port overflow, output, 1, sticky flag: an event was dropped.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, ON, GAP; led = 1 only in ON.
REQ-014 SHALL sample tick_in on every rising edge; every sampled-high cycle counts as one event, including consecutive high cycles.
REQ-015 IDLE + tick_in: SHALL enter ON at the next edge and load the timer for ON_CYCLES; pending stays 0.
REQ-016 SHALL hold ON for exactly ON_CYCLES cycles, then GAP for exactly OFF_CYCLES cycles (down-counting timer, terminal at 0).
REQ-017 On the last GAP cycle SHALL assert done_tick for exactly one cycle.
REQ-018 After the last GAP cycle: if pending > 0 or tick_in = 1, SHALL enter ON; otherwise enter IDLE.
REQ-019 tick_in in ON or GAP (other than the last GAP cycle) SHALL increment pending.
REQ-020 Last GAP cycle with pending > 0 and tick_in = 0: SHALL decrement pending.
REQ-021 Last GAP cycle with pending > 0 and tick_in = 1: pending SHALL stay unchanged (one queued, one dequeued).
REQ-022 Last GAP cycle with pending = 0 and tick_in = 1: SHALL go to ON with pending still 0.
REQ-023 pending SHALL saturate at 2^PEND_W-1; an increment attempted at saturation SHALL be dropped and SHALL set overflow.
REQ-024 overflow SHALL stay set until reset; no other clear path.
REQ-025 Back-to-back flashes SHALL always be separated by exactly OFF_CYCLES low cycles; led SHALL never glitch between cycles.
REQ-026 Latency: a tick sampled at edge t in IDLE SHALL give led high from edge t+1 through edge t+1+ON_CYCLES (exclusive).
REQ-027 Unreachable state encodings SHALL return to IDLE at the next edge.

Reset
REQ-028 On reset assertion SHALL immediately force state IDLE, timer 0, pending 0, led 0, busy 0, done_tick 0, overflow 0, including mid-flash or mid-gap.
REQ-029 tick_in SHALL be ignored while reset is high; the first edge after deassertion samples normally.

Verification (ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2)
REQ-030 Single tick at edge 10 in IDLE -> led high at edges 11-14, low at 15-17, done_tick at the cycle before edge 18, IDLE at 18, pending 0 throughout.
REQ-031 Three ticks at edges 10, 11, 12 -> pending reaches 2; three flashes, each 4 high / 3 low; pending 2→1→0 at the GAP-to-ON transitions; three done_ticks; final IDLE.
REQ-032 tick_in held high for 6 cycles starting in IDLE -> pending saturates at 3, overflow = 1; exactly 4 flashes; overflow still 1 afterwards.
REQ-033 Tick exactly in the last GAP cycle with pending = 1 -> pending stays 1, immediate ON, then one more flash, then IDLE.
REQ-034 Reset pulsed during the 2nd ON cycle with pending = 2 -> led, busy, pending and overflow all 0 immediately; a subsequent single tick yields exactly one flash.

Source files
------------

// File: rtl/event_flasher_if.sv
// event_flasher_if: event strobe in, flash status out.
// tick_in: event strobe; led: flash output; busy: not idle; pending: queued events;
// done_tick: flash/gap complete pulse; overflow: sticky dropped-event flag.
interface event_flasher_if #(parameter int PEND_W = 4);
  logic tick_in;
  logic led;
  logic busy;
  logic [PEND_W-1:0] pending;
  logic done_tick;
  logic overflow;
  modport master (output tick_in, input led, busy, pending, done_tick, overflow);
  modport slave (input tick_in, output led, busy, pending, done_tick, overflow);
endinterface

// File: rtl/event_flasher.sv
// event_flasher: turns event strobes into queued fixed-length LED flashes with mandatory gaps.
// clk: rising-edge clock; reset: async active-high; bus: event_flasher_if slave
// (tick_in in; led, busy, pending, done_tick, overflow out, all registered).
module event_flasher #(
  parameter int CNT_W = 10,
  parameter int ON_CYCLES = 1023,
  parameter int OFF_CYCLES = 1023,
  parameter int PEND_W = 4
) (
  input logic clk,
  input logic reset,
  event_flasher_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, GAP = 2'd2} state_t;
  localparam logic [CNT_W-1:0] ON_LOAD = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  state_t state;
  logic [CNT_W-1:0] timer;
  logic queue_tick;
  // The last GAP cycle handles its tick through the dequeue path instead.
  assign queue_tick = bus.tick_in && (state == ON || (state == GAP && timer != '0));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      bus.led <= 1'b0;
      bus.busy <= 1'b0;
      bus.pending <= '0;
      bus.done_tick <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done_tick <= 1'b0;
      case (state)
        IDLE:
          if (bus.tick_in) begin
            state <= ON;
            timer <= ON_LOAD;
            bus.led <= 1'b1;
            bus.busy <= 1'b1;
          end
        ON:
          if (timer == '0) begin
            state <= GAP;
            timer <= OFF_LOAD;
            bus.led <= 1'b0;
            bus.done_tick <= OFF_LOAD == '0;
          end else timer <= timer - CNT_W'(1);
        GAP:
          if (timer == '0) begin
            if (bus.pending != '0 || bus.tick_in) begin
              state <= ON;
              timer <= ON_LOAD;
              bus.led <= 1'b1;
              if (!bus.tick_in) bus.pending <= bus.pending - PEND_W'(1);
            end else begin
              state <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            timer <= timer - CNT_W'(1);
            bus.done_tick <= timer == CNT_W'(1);
          end
        default: begin
          state <= IDLE;
          timer <= '0;
          bus.led <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
      if (queue_tick) begin
        if (bus.pending == PEND_MAX) bus.overflow <= 1'b1;
        else bus.pending <= bus.pending + PEND_W'(1);
      end
    end
endmodule
